// File: rtl/sb_rx_pkg.sv
// Shared definitions for the sideband receive message engine: opcodes,
// header field positions, FSM states and the queued message record.
package sb_rx_pkg;

   localparam logic [4:0] OP_MSG_NODATA = 5'b10010;
   localparam logic [4:0] OP_MSG_DATA   = 5'b11011;

   localparam int OPC_LSB    = 0;
   localparam int CODE_LSB   = 14;
   localparam int SUB_LSB    = 32;
   localparam int INFO_LSB   = 40;
   localparam int DP_BIT     = 62;
   localparam int CP_BIT     = 63;
   // msginfo must end below the parity bits
   localparam int INFO_MAX_W = DP_BIT - INFO_LSB;

   localparam logic [63:0] SB_PATTERN_DEFAULT = 64'hAAAA_AAAA_AAAA_AAAA;

   typedef enum logic [1:0] {
      PAT_HUNT = 2'd0,
      MSG_HDR  = 2'd1,
      MSG_DATA = 2'd2
   } sb_rx_state_t;

   typedef struct packed {
      logic [7:0]            code;
      logic [7:0]            subcode;
      logic [INFO_MAX_W-1:0] info;
      logic                  has_data;
      logic [63:0]           data;
   } sb_rx_msg_t;

   function automatic logic hdr_cp_ok(input logic [63:0] w);
      return w[CP_BIT] == ^w[DP_BIT-1:0];
   endfunction

endpackage

// File: rtl/sb_rx_msg_engine_if.sv
// Ready/valid message bus from the receive engine to the LTSM/adapter.
interface sb_rx_msg_engine_if #(
   parameter int INFO_W = 16
) ();
   logic              msg_valid;
   logic              msg_ready;
   logic [7:0]        msg_code;
   logic [7:0]        msg_subcode;
   logic [INFO_W-1:0] msg_info;
   logic              msg_has_data;
   logic [63:0]       msg_data;

   modport master (
      output msg_valid, msg_code, msg_subcode, msg_info, msg_has_data, msg_data,
      input  msg_ready
   );

   modport slave (
      input  msg_valid, msg_code, msg_subcode, msg_info, msg_has_data, msg_data,
      output msg_ready
   );
endinterface

// File: rtl/sb_rx_msg_fifo.sv
// Synchronous message FIFO with a registered head; a push and a pop in the
// same cycle are both honoured even when full.
module sb_rx_msg_fifo
   import sb_rx_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_flush,
   input  logic       i_push,
   input  sb_rx_msg_t i_push_msg,
   input  logic       i_ready,
   output logic       o_valid,
   output sb_rx_msg_t o_head,
   output logic       o_pop,
   output logic       o_drop,
   output logic       o_full,
   output logic       o_empty,
   output logic [LW-1:0] o_level
);

   sb_rx_msg_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          valid_q, valid_d;
   sb_rx_msg_t    head_q, head_d;
   logic          pop, push_ok;

   assign pop     = valid_q & i_ready;
   assign o_full  = (level_q == LW'(DEPTH));
   assign o_empty = (level_q == '0);
   assign push_ok = i_push & (~o_full | pop);
   assign o_drop  = i_push & o_full & ~pop & ~i_flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      valid_d  = valid_q;
      head_d   = head_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         valid_d  = 1'b0;
         head_d   = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + AW'(pop);
         wr_ptr_d = wr_ptr_q + AW'(push_ok);
         level_d  = level_q - LW'(pop) + LW'(push_ok);
         // A word written this edge is not readable until the next one
         valid_d  = (level_q - LW'(pop)) != '0;
         head_d   = valid_d ? mem[rd_ptr_d] : '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_ok && !i_flush) begin
         mem[wr_ptr_q] <= i_push_msg;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
      end
   end

   assign o_valid = valid_q;
   assign o_head  = head_q;
   assign o_pop   = pop;
   assign o_level = level_q;

endmodule

// File: rtl/sb_rx_msg_engine.sv
// Sideband receive engine: pattern hunt, header/data decode with parity
// checks, and a ready/valid queue of accepted messages.
module sb_rx_msg_engine
   import sb_rx_pkg::*;
#(
   parameter int          SB_W        = 64,
   parameter int          FIFO_DEPTH  = 4,
   parameter int          PATTERN_CNT = 4,
   parameter int          INFO_W      = 16,
   parameter logic [63:0] PATTERN     = SB_PATTERN_DEFAULT
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_de_ser_done,
   input  logic [SB_W-1:0]               i_deser_data,
   input  logic                          i_ltsm_in_reset,
   output logic                          o_rx_sb_start_pattern,
   output logic                          o_rx_sb_pattern_samp_done,
   sb_rx_msg_engine_if.master            msg_if,
   output logic                          o_rx_rsp_delivered,
   output logic                          o_parity_error,
   output logic                          o_unknown_opcode,
   output logic                          o_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   if (SB_W != 64) begin : g_bad_sb_w
      $error("sb_rx_msg_engine: only SB_W=64 is supported");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sb_rx_msg_engine: FIFO_DEPTH must be a power of two >= 2");
   end
   if (PATTERN_CNT < 1 || PATTERN_CNT > 15) begin : g_bad_pcnt
      $error("sb_rx_msg_engine: PATTERN_CNT must be 1..15");
   end
   if (INFO_W < 1 || INFO_W > INFO_MAX_W) begin : g_bad_info
      $error("sb_rx_msg_engine: INFO_W out of range");
   end

   sb_rx_state_t state_q, state_d;
   logic [3:0]   pat_cnt_q, pat_cnt_d;
   logic         drop_q, drop_d;
   logic         dp_q, dp_d;
   sb_rx_msg_t   hdr_q, hdr_d;
   logic         start_q, start_d, samp_q, samp_d;
   logic         perr_q, perr_d, unk_q, unk_d;
   logic         deliv_q, ovf_q;
   logic         push;
   sb_rx_msg_t   push_msg, dec_msg, head;
   logic         fifo_pop, fifo_drop, fifo_full, fifo_empty;
   logic [63:0]  word;
   logic [4:0]   opcode;

   assign word   = i_deser_data;
   assign opcode = word[OPC_LSB +: 5];

   always_comb begin
      dec_msg          = '0;
      dec_msg.code     = word[CODE_LSB +: 8];
      dec_msg.subcode  = word[SUB_LSB +: 8];
      dec_msg.info     = INFO_MAX_W'(word[INFO_LSB +: INFO_W]);
   end

   always_comb begin
      state_d   = state_q;
      pat_cnt_d = pat_cnt_q;
      drop_d    = drop_q;
      dp_d      = dp_q;
      hdr_d     = hdr_q;
      start_d   = 1'b0;
      samp_d    = 1'b0;
      perr_d    = 1'b0;
      unk_d     = 1'b0;
      push      = 1'b0;
      push_msg  = dec_msg;
      if (i_ltsm_in_reset) begin
         state_d   = PAT_HUNT;
         pat_cnt_d = '0;
         drop_d    = 1'b0;
      end else if (i_de_ser_done) begin
         unique case (state_q)
            PAT_HUNT: begin
               if (word == PATTERN) begin
                  pat_cnt_d = pat_cnt_q + 4'd1;
                  start_d   = (pat_cnt_q == '0);
                  if (pat_cnt_q + 4'd1 == 4'(PATTERN_CNT)) begin
                     samp_d    = 1'b1;
                     pat_cnt_d = '0;
                     state_d   = MSG_HDR;
                  end
               end else begin
                  pat_cnt_d = '0;
               end
            end
            MSG_HDR: begin
               // Idle pattern between packets carries a valid CP, so filter it first
               if (word != PATTERN) begin
                  if (!hdr_cp_ok(word)) begin
                     perr_d = 1'b1;
                     if (opcode == OP_MSG_DATA) begin
                        state_d = MSG_DATA;
                        drop_d  = 1'b1;
                        dp_d    = word[DP_BIT];
                     end
                  end else if (opcode == OP_MSG_NODATA) begin
                     push = 1'b1;
                  end else if (opcode == OP_MSG_DATA) begin
                     hdr_d          = dec_msg;
                     hdr_d.has_data = 1'b1;
                     dp_d           = word[DP_BIT];
                     drop_d         = 1'b0;
                     state_d        = MSG_DATA;
                  end else begin
                     unk_d = 1'b1;
                  end
               end
            end
            MSG_DATA: begin
               push_msg      = hdr_q;
               push_msg.data = word;
               if ((^word) != dp_q) begin
                  perr_d = 1'b1;
               end else begin
                  push = ~drop_q;
               end
               drop_d  = 1'b0;
               state_d = MSG_HDR;
            end
            default: state_d = PAT_HUNT;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= PAT_HUNT;
         pat_cnt_q <= '0;
         drop_q    <= 1'b0;
         dp_q      <= 1'b0;
         hdr_q     <= '0;
         start_q   <= 1'b0;
         samp_q    <= 1'b0;
         perr_q    <= 1'b0;
         unk_q     <= 1'b0;
         deliv_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_cnt_q <= pat_cnt_d;
         drop_q    <= drop_d;
         dp_q      <= dp_d;
         hdr_q     <= hdr_d;
         start_q   <= start_d;
         samp_q    <= samp_d;
         perr_q    <= perr_d;
         unk_q     <= unk_d;
         deliv_q   <= fifo_pop & ~i_ltsm_in_reset;
         ovf_q     <= i_ltsm_in_reset ? 1'b0 : (ovf_q | fifo_drop);
      end
   end

   sb_rx_msg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_flush    (i_ltsm_in_reset),
      .i_push     (push),
      .i_push_msg (push_msg),
      .i_ready    (msg_if.msg_ready),
      .o_valid    (msg_if.msg_valid),
      .o_head     (head),
      .o_pop      (fifo_pop),
      .o_drop     (fifo_drop),
      .o_full     (fifo_full),
      .o_empty    (fifo_empty),
      .o_level    (o_fifo_level)
   );

   logic unused_ok;
   assign unused_ok = ^{fifo_full, fifo_empty, head.info};

   assign msg_if.msg_code     = head.code;
   assign msg_if.msg_subcode  = head.subcode;
   assign msg_if.msg_info     = head.info[INFO_W-1:0];
   assign msg_if.msg_has_data = head.has_data;
   assign msg_if.msg_data     = head.data;

   assign o_rx_sb_start_pattern     = start_q;
   assign o_rx_sb_pattern_samp_done = samp_q;
   assign o_rx_rsp_delivered        = deliv_q;
   assign o_parity_error            = perr_q;
   assign o_unknown_opcode          = unk_q;
   assign o_overflow                = ovf_q;

endmodule

// File: tb/tb_sb_rx_msg_engine.sv
// Directed bench for sb_rx_msg_engine: a per-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_sb_rx_msg_engine;

   localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [63:0] PAY = 64'hDEAD_BEEF_0123_4567;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        de = 1'b0;
   logic [63:0] din = '0;
   logic        ltsm = 1'b0;
   logic        start_p, samp_p, deliv_p, perr_p, unk_p, ovf;
   logic [2:0]  level;

   int tests = 0;
   int fails = 0;

   sb_rx_msg_engine_if #(.INFO_W(16)) msg_if ();

   sb_rx_msg_engine dut (
      .i_clk                     (clk),
      .i_rst_n                   (rst_n),
      .i_de_ser_done             (de),
      .i_deser_data              (din),
      .i_ltsm_in_reset           (ltsm),
      .o_rx_sb_start_pattern     (start_p),
      .o_rx_sb_pattern_samp_done (samp_p),
      .msg_if                    (msg_if),
      .o_rx_rsp_delivered        (deliv_p),
      .o_parity_error            (perr_p),
      .o_unknown_opcode          (unk_p),
      .o_overflow                (ovf),
      .o_fifo_level              (level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        de;
      logic [63:0] word;
      logic        ltsm;
      logic        rdy;
      logic [6:0]  flags;   // start, samp, perr, unk, valid, deliv, ovf
      logic [2:0]  lvl;
      logic [7:0]  code;
   } vec_t;

   vec_t vq[$];

   function automatic logic [63:0] mk_hdr(input logic [4:0] op, input logic [7:0] code,
                                          input logic [7:0] sub, input logic [15:0] info,
                                          input logic dp, input logic cp_bad);
      logic [63:0] w;
      w = '0;
      w[4:0]   = op;
      w[21:14] = code;
      w[39:32] = sub;
      w[55:40] = info;
      w[62]    = dp;
      w[63]    = (^w[61:0]) ^ cp_bad;
      return w;
   endfunction

   function automatic logic [63:0] nodata(input logic [7:0] code);
      return mk_hdr(5'b10010, code, 8'h01, 16'h1234, 1'b0, 1'b0);
   endfunction

   task automatic add(input logic d, input logic [63:0] w, input logic l, input logic r,
                      input logic [6:0] f, input logic [2:0] lv, input logic [7:0] c);
      vec_t v;
      v.de = d; v.word = w; v.ltsm = l; v.rdy = r; v.flags = f; v.lvl = lv; v.code = c;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] w);
      de  = 1'b1;
      din = w;
      tick();
      de  = 1'b0;
   endtask

   task automatic lock_pattern();
      for (int i = 0; i < 4; i++) send(PAT);
      chk("lock_samp_done", 64'(samp_p), 64'd1);
   endtask

   logic [63:0] data_hdr, bad_dp_hdr, bad_cp_hdr;

   initial begin
      msg_if.msg_ready = 1'b0;

      // start, samp, perr, unk, valid, deliv, ovf
      add(1, PAT, 0, 0, 7'b1000000, 3'd0, 8'h00);
      add(1, PAT, 0, 0, 7'b0000000, 3'd0, 8'h00);
      add(1, PAT, 0, 0, 7'b0000000, 3'd0, 8'h00);
      add(1, PAT, 0, 0, 7'b0100000, 3'd0, 8'h00);
      add(0, '0,  1, 0, 7'b0000000, 3'd0, 8'h00);
      add(1, PAT, 0, 0, 7'b1000000, 3'd0, 8'h00);
      add(1, PAT, 0, 0, 7'b0000000, 3'd0, 8'h00);
      add(1, '0,  0, 0, 7'b0000000, 3'd0, 8'h00);
      add(1, PAT, 0, 0, 7'b1000000, 3'd0, 8'h00);
      add(1, PAT, 0, 0, 7'b0000000, 3'd0, 8'h00);
      add(1, PAT, 0, 0, 7'b0000000, 3'd0, 8'h00);
      add(1, PAT, 0, 0, 7'b0100000, 3'd0, 8'h00);
      add(1, PAT, 0, 0, 7'b0000000, 3'd0, 8'h00);
      add(1, mk_hdr(5'b10010, 8'h85, 8'h01, 16'h1234, 1'b0, 1'b0), 0, 0, 7'b0000000, 3'd1, 8'h00);
      add(0, '0,  0, 0, 7'b0000100, 3'd1, 8'h85);
      add(0, '0,  0, 1, 7'b0000010, 3'd0, 8'h00);
      add(1, mk_hdr(5'b00001, 8'h10, 8'h00, 16'h0000, 1'b0, 1'b0), 0, 0, 7'b0001000, 3'd0, 8'h00);
      add(1, mk_hdr(5'b10010, 8'h20, 8'h00, 16'h0000, 1'b0, 1'b1), 0, 0, 7'b0010000, 3'd0, 8'h00);

      // Asynchronous reset state
      #2;
      chk("reset_outputs", {57'd0, start_p, samp_p, perr_p, unk_p, msg_if.msg_valid, deliv_p, ovf},
          64'd0);
      chk("reset_level", 64'(level), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vq[i]) begin
         logic [17:0] act, exp;
         de = vq[i].de; din = vq[i].word; ltsm = vq[i].ltsm; msg_if.msg_ready = vq[i].rdy;
         tick();
         act = {start_p, samp_p, perr_p, unk_p, msg_if.msg_valid, deliv_p, ovf, level,
                (msg_if.msg_valid ? msg_if.msg_code : 8'h00)};
         exp = {vq[i].flags, vq[i].lvl, vq[i].code};
         chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
      end
      de = 1'b0; ltsm = 1'b0; msg_if.msg_ready = 1'b0;
      tick();
      chk("vec_nodata_fields", {msg_if.msg_has_data, 16'(0), 8'(0), 8'(0), 31'(0)}, 64'd0);

      // DATA header plus payload with correct DP
      data_hdr = mk_hdr(5'b11011, 8'h9A, 8'h02, 16'h0055, ^PAY, 1'b0);
      send(data_hdr);
      chk("data_hdr_level", 64'(level), 64'd0);
      send(PAY);
      chk("data_push_level", 64'(level), 64'd1);
      chk("data_no_perr", 64'(perr_p), 64'd0);
      tick();
      chk("data_valid", 64'(msg_if.msg_valid), 64'd1);
      chk("data_code", 64'(msg_if.msg_code), 64'h9A);
      chk("data_sub_info", {msg_if.msg_subcode, msg_if.msg_info}, 64'h02_0055);
      chk("data_has_data", 64'(msg_if.msg_has_data), 64'd1);
      chk("data_payload", msg_if.msg_data, PAY);
      msg_if.msg_ready = 1'b1;
      tick();
      msg_if.msg_ready = 1'b0;
      chk("data_delivered", 64'(deliv_p), 64'd1);
      chk("data_drained", 64'(level), 64'd0);

      // Flipped DP
      bad_dp_hdr = mk_hdr(5'b11011, 8'h9B, 8'h02, 16'h0055, ~(^PAY), 1'b0);
      send(bad_dp_hdr);
      send(PAY);
      chk("dp_bad_perr", 64'(perr_p), 64'd1);
      chk("dp_bad_level", 64'(level), 64'd0);

      // Bad CP on a DATA header swallows its payload
      bad_cp_hdr = mk_hdr(5'b11011, 8'h9C, 8'h02, 16'h0055, ^PAY, 1'b1);
      send(bad_cp_hdr);
      chk("cp_bad_perr", 64'(perr_p), 64'd1);
      send(PAY);
      chk("cp_bad_payload_no_perr", 64'(perr_p), 64'd0);
      chk("cp_bad_no_push", 64'(level), 64'd0);
      send(nodata(8'h33));
      chk("after_cp_bad_push", 64'(level), 64'd1);
      tick();
      chk("after_cp_bad_code", 64'(msg_if.msg_code), 64'h33);
      msg_if.msg_ready = 1'b1;
      tick();
      msg_if.msg_ready = 1'b0;

      // Backpressure: five messages into a four-deep queue
      for (int i = 1; i <= 5; i++) send(nodata(8'(i)));
      chk("bp_level_full", 64'(level), 64'd4);
      chk("bp_overflow", 64'(ovf), 64'd1);
      msg_if.msg_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("bp_head%0d", i), {msg_if.msg_valid, msg_if.msg_code}, {1'b1, 8'(i)});
         tick();
         chk($sformatf("bp_deliv%0d", i), 64'(deliv_p), 64'd1);
      end
      msg_if.msg_ready = 1'b0;
      chk("bp_empty", {msg_if.msg_valid, level}, 64'd0);
      chk("bp_overflow_sticky", 64'(ovf), 64'd1);

      // In-band reset clears overflow; strobes during it are ignored
      ltsm = 1'b1; de = 1'b1; din = PAT;
      tick();
      ltsm = 1'b0; de = 1'b0;
      chk("ltsm_clears_ovf", {ovf, start_p}, 64'd0);

      // Push and pop together at full
      lock_pattern();
      for (int i = 0; i < 4; i++) send(nodata(8'h11 + 8'(i)));
      tick();
      chk("full_head", {msg_if.msg_valid, msg_if.msg_code, level}, {1'b1, 8'h11, 3'd4});
      msg_if.msg_ready = 1'b1;
      send(nodata(8'h15));
      msg_if.msg_ready = 1'b0;
      chk("full_pushpop", {deliv_p, ovf, level}, {1'b1, 1'b0, 3'd4});
      chk("full_next_head", {msg_if.msg_valid, msg_if.msg_code}, {1'b1, 8'h12});

      // In-band reset mid-DATA packet with two queued messages
      ltsm = 1'b1; tick(); ltsm = 1'b0;
      lock_pattern();
      send(nodata(8'h41));
      send(nodata(8'h42));
      send(data_hdr);
      chk("flush_pre_level", 64'(level), 64'd2);
      ltsm = 1'b1;
      tick();
      ltsm = 1'b0;
      chk("flush_state", {msg_if.msg_valid, ovf, level}, 64'd0);
      send(PAY);
      send(nodata(8'h43));
      tick();
      chk("flush_needs_pattern", {msg_if.msg_valid, level}, 64'd0);
      lock_pattern();
      send(nodata(8'h77));
      tick();
      chk("flush_recovered", {msg_if.msg_valid, msg_if.msg_code, level}, {1'b1, 8'h77, 3'd1});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
